// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V control path: states, opcodes, mux codes, control vector.
// MULTICYCLE_BJ_EN enables the branch/jump (BEQ/JAL) encodings.
package multicycle_control_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned IMM_SRC_W = 2;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;

    localparam logic [IMM_SRC_W-1:0] IMM_I = 2'b00;
    localparam logic [IMM_SRC_W-1:0] IMM_S = 2'b01;
`ifdef MULTICYCLE_BJ_EN
    localparam logic [IMM_SRC_W-1:0] IMM_B = 2'b10;
    localparam logic [IMM_SRC_W-1:0] IMM_J = 2'b11;
`endif

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEM    = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

    localparam logic [SEL_W-1:0] A_PC    = 2'b00;
    localparam logic [SEL_W-1:0] A_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] A_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] B_RS2   = 2'b00;
    localparam logic [SEL_W-1:0] B_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] B_FOUR  = 2'b10;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic                 pc_update;
        logic                 branch;
        logic                 adr_src;
        logic                 mem_write;
        logic                 ir_write;
        logic [SEL_W-1:0]     result_src;
        logic [SEL_W-1:0]     alu_src_a;
        logic [SEL_W-1:0]     alu_src_b;
        logic [SEL_W-1:0]     alu_op;
        logic                 reg_write;
        logic [IMM_SRC_W-1:0] imm_src;
        logic                 illegal_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE: return 1'b1;
`ifdef MULTICYCLE_BJ_EN
            OP_BEQ, OP_JAL:                        return 1'b1;
`else
            OP_BEQ, OP_JAL:                        return 1'b0;
`endif
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_ctrl_out_decoder.sv
// Combinational state+opcode -> datapath control vector; unlisted fields are 0 in every state.
// MULTICYCLE_BJ_EN adds the BEQ/JAL output rows and B/J immediate formats.
module ctrl_out_decoder
    import multicycle_control_pkg::*;
(
    input  state_t              state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = A_PC;
                ctrl.alu_src_b  = B_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
            end
            DECODE: begin
                // oldPC + imm precomputes the branch/jump target into ALUOut
                ctrl.alu_src_a  = A_OLDPC;
                ctrl.alu_src_b  = B_IMM;
                ctrl.alu_op     = ALU_ADD;
`ifdef MULTICYCLE_BJ_EN
                ctrl.imm_src    = (opcode == OP_JAL) ? IMM_J : IMM_B;
`else
                ctrl.imm_src    = IMM_I;
`endif
                ctrl.illegal_op = ~op_supported(opcode);
            end
            MEMADR: begin
                ctrl.alu_src_a = A_RS1;
                ctrl.alu_src_b = B_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            MEMREAD: begin
                ctrl.adr_src = 1'b1;
            end
            MEMWB: begin
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            EXECUTER: begin
                ctrl.alu_src_a = A_RS1;
                ctrl.alu_src_b = B_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            EXECUTEI: begin
                ctrl.alu_src_a = A_RS1;
                ctrl.alu_src_b = B_IMM;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
`ifdef MULTICYCLE_BJ_EN
            BEQ: begin
                ctrl.alu_src_a  = A_RS1;
                ctrl.alu_src_b  = B_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            JAL: begin
                ctrl.alu_src_a  = A_OLDPC;
                ctrl.alu_src_b  = B_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V core: state register, next-state logic, write gating.
// MULTICYCLE_BJ_EN enables the BEQ and JAL instruction paths.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic [SEL_W-1:0]     result_src,
    output logic [SEL_W-1:0]     alu_src_a,
    output logic [SEL_W-1:0]     alu_src_b,
    output logic [SEL_W-1:0]     alu_op,
    output logic                 reg_write,
    output logic [IMM_SRC_W-1:0] imm_src,
    output logic                 illegal_op
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Any encoding not listed (including X) falls back to FETCH
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECUTER;
                    OP_ITYPE:          state_next = EXECUTEI;
`ifdef MULTICYCLE_BJ_EN
                    OP_BEQ:            state_next = BEQ;
                    OP_JAL:            state_next = JAL;
`endif
                    default:           state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
`ifdef MULTICYCLE_BJ_EN
            BEQ:      state_next = FETCH;
            JAL:      state_next = ALUWB;
`endif
            default:  state_next = FETCH;
        endcase
    end

    ctrl_out_decoder u_dec (
        .state     (state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Write strobes are suppressed for the whole time reset is high
    assign pc_write   = ~reset & (ctrl.pc_update | (ctrl.branch & zero));
    assign ir_write   = ~reset & ctrl.ir_write;
    assign reg_write  = ~reset & ctrl.reg_write;
    assign mem_write  = ~reset & ctrl.mem_write;
    assign illegal_op = ~reset & ctrl.illegal_op;

    assign adr_src    = ctrl.adr_src;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign imm_src    = ctrl.imm_src;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; every cycle compares the full control vector.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .imm_src    (imm_src),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, alu_op, reg_write, imm_src, illegal_op}
    logic [15:0] obs;
    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                  alu_op, reg_write, imm_src, illegal_op};

    function automatic logic [15:0] v(input logic pcw, input logic adr, input logic memw,
                                      input logic irw, input logic [1:0] res, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] op, input logic regw,
                                      input logic [1:0] imm, input logic ill);
        return {pcw, adr, memw, irw, res, a, b, op, regw, imm, ill};
    endfunction

`ifdef MULTICYCLE_BJ_EN
    localparam logic [1:0] DEC_IMM = 2'b10;
`else
    localparam logic [1:0] DEC_IMM = 2'b00;
`endif

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    // Expected vectors per state, hand-derived from the control table
    localparam logic [15:0] E_F1    = 16'b0_0_0_1_10_00_10_00_0_00_0 | 16'h8000;
    localparam logic [15:0] E_F0    = 16'b0_0_0_0_10_00_10_00_0_00_0;
    localparam logic [15:0] E_DEC   = {4'b0000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, DEC_IMM, 1'b0};
    localparam logic [15:0] E_ILL   = {4'b0000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, DEC_IMM, 1'b1};
    localparam logic [15:0] E_EXR   = 16'b0_0_0_0_00_10_00_10_0_00_0;
    localparam logic [15:0] E_EXI   = 16'b0_0_0_0_00_10_01_10_0_00_0;
    localparam logic [15:0] E_ALUWB = 16'b0_0_0_0_00_00_00_00_1_00_0;
    localparam logic [15:0] E_MA_L  = 16'b0_0_0_0_00_10_01_00_0_00_0;
    localparam logic [15:0] E_MA_S  = 16'b0_0_0_0_00_10_01_00_0_01_0;
    localparam logic [15:0] E_MR    = 16'b0_1_0_0_00_00_00_00_0_00_0;
    localparam logic [15:0] E_MWB   = 16'b0_0_0_0_01_00_00_00_1_00_0;
    localparam logic [15:0] E_MW    = 16'b0_1_1_0_00_00_00_00_0_00_0;

    task automatic chk(input string tag, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b required=%b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input string tag, input logic [15:0] exp);
        @(negedge clk);
        chk(tag, exp);
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; opcode = OPC_R; zero = 1'b0;
        nxt();
        chk("reset_fetch_gated", E_F0);
        chk("reset_fn_check", v(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0));
        reset = 1'b0;

        // add: 4 cycles
        opcode = OPC_R;
        at("add_c0_fetch", E_F1); nxt();
        at("add_c1_decode", E_DEC); nxt();
        at("add_c2_execr", E_EXR); nxt();
        at("add_c3_aluwb", E_ALUWB); nxt();

        // addi: 4 cycles
        opcode = OPC_I;
        at("addi_c0_fetch", E_F1); nxt();
        at("addi_c1_decode", E_DEC); nxt();
        at("addi_c2_execi", E_EXI); nxt();
        at("addi_c3_aluwb", E_ALUWB); nxt();

        // lw with memory stalled three cycles in MEMREAD
        opcode = OPC_LW;
        at("lw_fetch", E_F1); nxt();
        at("lw_decode", E_DEC); nxt();
        at("lw_memadr", E_MA_L); nxt();
        mem_ready = 1'b0;
        at("lw_memread_wait0", E_MR); nxt();
        at("lw_memread_wait1", E_MR); nxt();
        at("lw_memread_wait2", E_MR); nxt();
        mem_ready = 1'b1;
        at("lw_memread_ready", E_MR); nxt();
        at("lw_memwb", E_MWB); nxt();

        // sw with memory stalled two cycles in MEMWRITE
        opcode = OPC_SW;
        at("sw_fetch", E_F1); nxt();
        at("sw_decode", E_DEC); nxt();
        at("sw_memadr_imm_s", E_MA_S); nxt();
        mem_ready = 1'b0;
        at("sw_memwrite_wait0", E_MW); nxt();
        at("sw_memwrite_wait1", E_MW); nxt();
        mem_ready = 1'b1;
        at("sw_memwrite_ready", E_MW); nxt();

        // fetch stall: no IR/PC load until memory is ready
        opcode = OPC_R;
        mem_ready = 1'b0;
        at("stall_fetch0", E_F0); nxt();
        at("stall_fetch1", E_F0); nxt();
        mem_ready = 1'b1;
        at("stall_fetch_ready", E_F1); nxt();
        at("stall_decode", E_DEC); nxt();
        at("stall_execr", E_EXR); nxt();
        at("stall_aluwb", E_ALUWB); nxt();

        // beq taken / not taken
        opcode = OPC_BEQ; zero = 1'b1;
        at("beq1_fetch", E_F1); nxt();
`ifdef MULTICYCLE_BJ_EN
        at("beq1_decode", E_DEC); nxt();
        at("beq1_taken", 16'b1_0_0_0_00_10_00_01_0_00_0); nxt();
`else
        at("beq1_illegal", E_ILL); nxt();
`endif
        zero = 1'b0;
        at("beq0_fetch", E_F1); nxt();
`ifdef MULTICYCLE_BJ_EN
        at("beq0_decode", E_DEC); nxt();
        at("beq0_not_taken", 16'b0_0_0_0_00_10_00_01_0_00_0); nxt();
`else
        at("beq0_illegal", E_ILL); nxt();
`endif

        // jal
        opcode = OPC_JAL;
        at("jal_fetch", E_F1); nxt();
`ifdef MULTICYCLE_BJ_EN
        at("jal_decode_imm_j", 16'b0_0_0_0_00_01_01_00_0_11_0); nxt();
        at("jal_state", 16'b1_0_0_0_00_01_10_00_0_00_0); nxt();
        at("jal_aluwb", E_ALUWB); nxt();
`else
        at("jal_illegal", E_ILL); nxt();
`endif

        // unsupported opcode: one-cycle illegal pulse, straight back to FETCH
        opcode = OPC_BAD;
        at("bad_fetch", E_F1); nxt();
        at("bad_decode_illegal", E_ILL); nxt();
        at("bad_next_fetch", E_F1);

        // reset asserted in the middle of a stalled store
        opcode = OPC_SW;
        nxt();
        at("rst_sw_decode", E_DEC); nxt();
        at("rst_sw_memadr", E_MA_S); nxt();
        mem_ready = 1'b0;
        at("rst_sw_memwrite", E_MW);
        #2;
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        chk("reset_mid_memwrite", E_F0);
        nxt();
        reset = 1'b0;
        at("after_reset_fetch", E_F1); nxt();
        at("after_reset_decode", E_DEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
